// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding, array geometry and default widths for the tile sequencer
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 8
`endif
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif
package systolic_pkg;
    localparam int ARRAY_DIM = 4;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT_DONE, DRAIN} seq_state_t;
    typedef logic [1:0] row_idx_t;
endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// systolic_tile_sequencer_if: host command channel and valid/ready result-row channel
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif
interface systolic_tile_sequencer_if
    import systolic_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 8,
    parameter int ACC_WIDTH   = `SYSTOLIC_RESULT_WIDTH
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [ADDR_WIDTH-1:0]          cmd_a_base;
    logic [ADDR_WIDTH-1:0]          cmd_b_base;
    logic [COUNT_WIDTH-1:0]         cmd_tile_count;
    logic                           res_valid;
    logic                           res_ready;
    logic [ACC_WIDTH*ARRAY_DIM-1:0] res_data;
    row_idx_t                       res_row;
    logic                           res_last;
    modport master (
        output cmd_valid, cmd_a_base, cmd_b_base, cmd_tile_count, res_ready,
        input  cmd_ready, res_valid, res_data, res_row, res_last
    );
    modport slave (
        input  cmd_valid, cmd_a_base, cmd_b_base, cmd_tile_count, res_ready,
        output cmd_ready, res_valid, res_data, res_row, res_last
    );
endinterface

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: 16-entry accumulator capture buffer serialised one row per valid/ready beat
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     capture,
    input  logic                                     active,
    input  logic                                     last_tile,
    input  logic                                     res_ready,
    input  logic [ACC_WIDTH*ARRAY_DIM*ARRAY_DIM-1:0] tile_result,
    output logic                                     res_valid,
    output logic [ACC_WIDTH*ARRAY_DIM-1:0]           res_data,
    output row_idx_t                                 res_row,
    output logic                                     res_last,
    output logic                                     row_done
);
    logic [ACC_WIDTH*ARRAY_DIM*ARRAY_DIM-1:0] res_buf_q, res_buf_d;
    row_idx_t row_q, row_d;

    // capture the whole tile on done; the row index restarts per tile and steps on each accepted row
    always_comb begin
        res_buf_d = capture ? tile_result : res_buf_q;
        row_d     = capture ? '0 : (active && res_ready) ? row_q + row_idx_t'(1) : row_q;
    end

    // buffer and row index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_buf_q <= '0;
            row_q     <= '0;
        end else begin
            res_buf_q <= res_buf_d;
            row_q     <= row_d;
        end
    end

    // present the current row only while draining; it holds until accepted
    always_comb begin
        res_valid = active;
        res_data  = active ? res_buf_q[int'(row_q)*ARRAY_DIM*ACC_WIDTH +: ARRAY_DIM*ACC_WIDTH] : '0;
        res_row   = active ? row_q : '0;
        res_last  = active && last_tile && row_q == row_idx_t'(ARRAY_DIM-1);
        row_done  = active && res_ready && row_q == row_idx_t'(ARRAY_DIM-1);
    end
endmodule

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: steps a 4x4 systolic array through clear/feed/wait/drain per tile; SYSTOLIC_SEQ_PERF_EN adds perf counters
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 8
`endif
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif
module systolic_tile_sequencer
    import systolic_pkg::*;
#(
    parameter int INPUT_WIDTH   = `SYSTOLIC_INPUT_WIDTH,
    parameter int ACC_WIDTH     = `SYSTOLIC_RESULT_WIDTH,
    parameter int VECTOR_LENGTH = 4,
    parameter int ADDR_WIDTH    = 10,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    systolic_tile_sequencer_if.slave                 bus,
    output logic                                     rd_en,
    output logic [ADDR_WIDTH-1:0]                    rd_a_addr,
    output logic [ADDR_WIDTH-1:0]                    rd_b_addr,
    input  logic [INPUT_WIDTH*ARRAY_DIM-1:0]         rd_a_data,
    input  logic [INPUT_WIDTH*ARRAY_DIM-1:0]         rd_b_data,
    output logic                                     arr_tile_clear,
    output logic                                     arr_feed_valid,
    output logic [INPUT_WIDTH*ARRAY_DIM-1:0]         arr_row_data,
    output logic [INPUT_WIDTH*ARRAY_DIM-1:0]         arr_col_data,
    input  logic                                     arr_ready_for_feed,
    input  logic                                     arr_tile_done,
    input  logic [ACC_WIDTH*ARRAY_DIM*ARRAY_DIM-1:0] arr_tile_result,
    output logic                                     seq_done,
    output logic                                     seq_err,
    output logic [31:0]                              perf_busy_cycles,
    output logic [31:0]                              perf_stall_cycles
);
    seq_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, beat_q, beat_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic feed_valid_q, seq_done_q, seq_done_d, seq_err_q, seq_err_d;
    logic accept, last_tile, tile_end;

    assign accept    = bus.cmd_valid && bus.cmd_ready;
    assign last_tile = count_q == COUNT_WIDTH'(1);

    systolic_result_drain #(.ACC_WIDTH(ACC_WIDTH)) u_drain (
        .clk         (clk),
        .rst         (rst),
        .capture     (state_q == WAIT_DONE && arr_tile_done),
        .active      (state_q == DRAIN),
        .last_tile   (last_tile),
        .res_ready   (bus.res_ready),
        .tile_result (arr_tile_result),
        .res_valid   (bus.res_valid),
        .res_data    (bus.res_data),
        .res_row     (bus.res_row),
        .res_last    (bus.res_last),
        .row_done    (tile_end)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: zero-count commands stay idle, the last tile's final row returns to idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      state_d = (accept && bus.cmd_tile_count != '0) ? CLEAR : IDLE;
            CLEAR:     state_d = arr_ready_for_feed ? FEED : CLEAR;
            FEED:      state_d = (beat_q == ADDR_WIDTH'(VECTOR_LENGTH-1)) ? WAIT_DONE : FEED;
            WAIT_DONE: state_d = arr_tile_done ? DRAIN : WAIT_DONE;
            DRAIN:     state_d = tile_end ? (last_tile ? IDLE : CLEAR) : DRAIN;
            default:   state_d = IDLE;
        endcase
    end

    // command latch, per-tile pointer advance, beat counter, done pulse and sticky error
    always_comb begin
        a_ptr_d    = a_ptr_q;
        b_ptr_d    = b_ptr_q;
        count_d    = count_q;
        seq_done_d = 1'b0;
        beat_d     = (state_q == FEED) ? beat_q + ADDR_WIDTH'(1) : '0;
        seq_err_d  = seq_err_q || (arr_tile_done && state_q != WAIT_DONE);
        if (accept) begin
            a_ptr_d    = bus.cmd_a_base;
            b_ptr_d    = bus.cmd_b_base;
            count_d    = bus.cmd_tile_count;
            seq_done_d = bus.cmd_tile_count == '0;
        end
        if (tile_end) begin
            a_ptr_d    = a_ptr_q + ADDR_WIDTH'(VECTOR_LENGTH);
            b_ptr_d    = b_ptr_q + ADDR_WIDTH'(VECTOR_LENGTH);
            count_d    = count_q - COUNT_WIDTH'(1);
            seq_done_d = last_tile;
        end
    end

    // datapath registers; feed_valid trails rd_en by the SRAM's one-cycle latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ptr_q      <= '0;
            b_ptr_q      <= '0;
            count_q      <= '0;
            beat_q       <= '0;
            feed_valid_q <= 1'b0;
            seq_done_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            a_ptr_q      <= a_ptr_d;
            b_ptr_q      <= b_ptr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            feed_valid_q <= rd_en;
            seq_done_q   <= seq_done_d;
            seq_err_q    <= seq_err_d;
        end
    end

    // outputs; cmd_ready stays low during the done pulse so the next command lands a cycle later
    always_comb begin
        bus.cmd_ready  = state_q == IDLE && !seq_done_q;
        arr_tile_clear = state_q == CLEAR && arr_ready_for_feed;
        rd_en          = state_q == FEED;
        rd_a_addr      = rd_en ? a_ptr_q + beat_q : '0;
        rd_b_addr      = rd_en ? b_ptr_q + beat_q : '0;
        arr_feed_valid = feed_valid_q;
        arr_row_data   = feed_valid_q ? rd_a_data : '0;
        arr_col_data   = feed_valid_q ? rd_b_data : '0;
        seq_done       = seq_done_q;
        seq_err        = seq_err_q;
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] busy_q, busy_d, stall_q, stall_d;

    // saturating busy/stall counters, restarted by each accepted command
    always_comb begin
        busy_d  = accept ? '0 : (state_q != IDLE && busy_q != '1) ? busy_q + 32'd1 : busy_q;
        stall_d = accept ? '0 : (state_q == DRAIN && !bus.res_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    end

    // counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign perf_busy_cycles  = busy_q;
    assign perf_stall_cycles = stall_q;
`else
    assign perf_busy_cycles  = '0;
    assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb_systolic_tile_sequencer: directed tests against an operand SRAM, a behavioural array and a result scoreboard
module tb_systolic_tile_sequencer;
    localparam int IW = 8, AW = 32, VL = 4, ADW = 10, CW = 8, LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_tile_sequencer_if #(.ADDR_WIDTH(ADW), .COUNT_WIDTH(CW), .ACC_WIDTH(AW)) bus ();

    logic rd_en, arr_tile_clear, arr_feed_valid, arr_ready_for_feed, arr_tile_done, seq_done, seq_err;
    logic [ADW-1:0] rd_a_addr, rd_b_addr;
    logic [IW*4-1:0] rd_a_data = '0, rd_b_data = '0, arr_row_data, arr_col_data;
    logic [AW*16-1:0] arr_tile_result;
    logic [31:0] perf_busy_cycles, perf_stall_cycles;

    systolic_tile_sequencer #(
        .INPUT_WIDTH(IW), .ACC_WIDTH(AW), .VECTOR_LENGTH(VL), .ADDR_WIDTH(ADW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .arr_tile_clear(arr_tile_clear), .arr_feed_valid(arr_feed_valid),
        .arr_row_data(arr_row_data), .arr_col_data(arr_col_data),
        .arr_ready_for_feed(arr_ready_for_feed), .arr_tile_done(arr_tile_done),
        .arr_tile_result(arr_tile_result),
        .seq_done(seq_done), .seq_err(seq_err),
        .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned el(input logic [31:0] w, input int e);
        return int'(w[e*IW +: IW]);
    endfunction

    // operand SRAM with one-cycle read latency
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a_data <= mem_a[rd_a_addr];
            rd_b_data <= mem_b[rd_b_addr];
        end
    end

    // behavioural 4x4 array: acc[r][c] += row[r]*col[c] per beat, done LAT cycles after the last beat
    logic [31:0] acc [16];
    int beats, lat;
    logic busy, model_done;
    logic force_done = 1'b0, hold_ready = 1'b0;
    assign arr_ready_for_feed = !busy && !hold_ready;
    assign arr_tile_done = model_done || force_done;
    always_comb for (int i = 0; i < 16; i++) arr_tile_result[i*AW +: AW] = acc[i];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) acc[i] <= '0;
            beats <= 0; lat <= 0; busy <= 1'b0; model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (arr_tile_clear) begin
                for (int i = 0; i < 16; i++) acc[i] <= '0;
                beats <= 0; busy <= 1'b1;
            end else if (arr_feed_valid) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        acc[r*4+c] <= acc[r*4+c] + arr_row_data[r*IW +: IW] * arr_col_data[c*IW +: IW];
                beats <= beats + 1;
                if (beats == VL-1) lat <= LAT;
            end else if (lat > 0) begin
                lat <= lat - 1;
                if (lat == 1) begin model_done <= 1'b1; busy <= 1'b0; end
            end
        end
    end

    // result-port consumer: always ready, or 0,0,1 per row under backpressure
    logic bp = 1'b0;
    int bp_ph = 0;
    always @(posedge clk) begin
        #1;
        if (bp && bus.res_valid) begin
            bus.res_ready = (bp_ph == 2);
            bp_ph = (bp_ph == 2) ? 0 : bp_ph + 1;
        end else begin
            bus.res_ready = !bp;
            bp_ph = 0;
        end
    end

    // scoreboard: expected reads and rows derived from memory contents by matrix arithmetic
    logic [ADW-1:0] exp_ra[$], exp_rb[$];
    logic [AW*4-1:0] exp_rd[$];
    logic [1:0] exp_rr[$];
    logic exp_rl[$];
    logic [AW*4-1:0] rx_log[$];
    logic [2*ADW-1:0] rd_log[$];
    logic exp_err = 1'b0;
    int done_cnt = 0, clear_cnt = 0, rd_cnt = 0, row_cnt = 0, last_cnt = 0;

    // compare process: checks every non-reset cycle against the scoreboard
    logic done_pend = 1'b0, pv_stall = 1'b0, pv_last = 1'b0;
    logic [AW*4-1:0] pv_data = '0;
    logic [1:0] pv_row = '0;
    always @(negedge clk) begin
        if (rst) begin
            done_pend = 1'b0;
            pv_stall = 1'b0;
        end else begin
            chk("seq_done", seq_done, done_pend);
            done_pend = 1'b0;
            if (seq_done) done_cnt++;
            chk("seq_err", seq_err, exp_err);
            if (arr_tile_clear) begin
                clear_cnt++;
                chk("clear_ready", arr_ready_for_feed, 1);
            end
            if (rd_en) begin
                rd_cnt++;
                rd_log.push_back({rd_a_addr, rd_b_addr});
                if (exp_ra.size() == 0) chk("rd_unexpected", rd_en, 0);
                else begin
                    chk("rd_a_addr", rd_a_addr, exp_ra.pop_front());
                    chk("rd_b_addr", rd_b_addr, exp_rb.pop_front());
                end
            end
            if (pv_stall)
                chk("stall_hold", {bus.res_valid, bus.res_last, bus.res_row, bus.res_data}, {1'b1, pv_last, pv_row, pv_data});
            if (bus.res_valid && bus.res_ready) begin
                row_cnt++;
                rx_log.push_back(bus.res_data);
                if (bus.res_last) last_cnt++;
                if (exp_rd.size() == 0) chk("res_unexpected", bus.res_valid, 0);
                else begin
                    chk("res_data", bus.res_data, exp_rd.pop_front());
                    chk("res_row", bus.res_row, exp_rr.pop_front());
                    done_pend = exp_rl.pop_front();
                    chk("res_last", bus.res_last, done_pend);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready && bus.cmd_tile_count == '0) done_pend = 1'b1;
            pv_stall = bus.res_valid && !bus.res_ready;
            pv_data = bus.res_data;
            pv_row = bus.res_row;
            pv_last = bus.res_last;
        end
    end

    task automatic issue(input int a, input int b, input int n);
        logic ok;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < VL; k++) begin
                exp_ra.push_back(ADW'(a + VL*t + k));
                exp_rb.push_back(ADW'(b + VL*t + k));
            end
            for (int r = 0; r < 4; r++) begin
                logic [AW*4-1:0] row;
                row = '0;
                for (int c = 0; c < 4; c++) begin
                    int unsigned s;
                    s = 0;
                    for (int k = 0; k < VL; k++)
                        s += el(mem_a[(a + VL*t + k) % 1024], r) * el(mem_b[(b + VL*t + k) % 1024], c);
                    row[c*AW +: AW] = s;
                end
                exp_rd.push_back(row);
                exp_rr.push_back(2'(r));
                exp_rl.push_back(t == n-1 && r == 3);
            end
        end
        bus.cmd_a_base = ADW'(a);
        bus.cmd_b_base = ADW'(b);
        bus.cmd_tile_count = CW'(n);
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 400 && done_cnt <= d0; i++) @(posedge clk);
        chk("done_seen", done_cnt > d0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rd_left", exp_ra.size(), 0);
        chk("res_left", exp_rd.size(), 0);
    endtask

    int c0, d0, r0, l0, q0;
    logic ok;

    initial begin
        for (int i = 0; i < 1024; i++)
            for (int e = 0; e < 4; e++) begin
                mem_a[i][e*IW +: IW] = IW'((i*3 + e*5) % 16);
                mem_b[i][e*IW +: IW] = IW'((i + e*7 + 1) % 16);
            end
        for (int k = 0; k < 4; k++)
            for (int e = 0; e < 4; e++) begin
                mem_a[500+k][e*IW +: IW] = IW'(e == k);
                mem_b[600+k][e*IW +: IW] = IW'(4*k + e + 1);
            end
        bus.cmd_valid = 1'b0;
        bus.cmd_a_base = '0;
        bus.cmd_b_base = '0;
        bus.cmd_tile_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_tile_clear", arr_tile_clear, 0);
        chk("rst_feed_valid", arr_feed_valid, 0);
        chk("rst_perf", {perf_busy_cycles, perf_stall_cycles}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // identity: rows of B come back unchanged; clear waits for the array
        hold_ready = 1'b1;
        c0 = clear_cnt; d0 = done_cnt; r0 = row_cnt; l0 = last_cnt; q0 = rx_log.size();
        issue(500, 600, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("id_clear_wait", clear_cnt - c0, 0);
        chk("id_busy_cmd_ready", bus.cmd_ready, 0);
        hold_ready = 1'b0;
        wait_done(d0);
        chk("id_clear", clear_cnt - c0, 1);
        chk("id_done", done_cnt - d0, 1);
        chk("id_rows", row_cnt - r0, 4);
        chk("id_last", last_cnt - l0, 1);
        chk("id_row0", rx_log[q0], {32'd4, 32'd3, 32'd2, 32'd1});
        chk("id_row1", rx_log[q0+1], {32'd8, 32'd7, 32'd6, 32'd5});
        chk("id_row2", rx_log[q0+2], {32'd12, 32'd11, 32'd10, 32'd9});
        chk("id_row3", rx_log[q0+3], {32'd16, 32'd15, 32'd14, 32'd13});

        // multi-tile: three tiles walking both operand bases
        c0 = clear_cnt; d0 = done_cnt; r0 = row_cnt; l0 = last_cnt; q0 = rd_log.size();
        issue(0, 100, 3);
        wait_done(d0);
        chk("mt_clear", clear_cnt - c0, 3);
        chk("mt_rows", row_cnt - r0, 12);
        chk("mt_last", last_cnt - l0, 1);
        chk("mt_rd0", rd_log[q0], {10'd0, 10'd100});
        chk("mt_rd4", rd_log[q0+4], {10'd4, 10'd104});
        chk("mt_rd11", rd_log[q0+11], {10'd11, 10'd111});

        // backpressure: each row stalls twice
        bp = 1'b1;
        r0 = row_cnt; d0 = done_cnt;
        issue(20, 40, 1);
        wait_done(d0);
        bp = 1'b0;
        chk("bp_rows", row_cnt - r0, 4);
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("bp_stall_cycles", perf_stall_cycles, 8);
`else
        chk("bp_stall_cycles", perf_stall_cycles, 0);
`endif

        // zero count: immediate done, no reads or clears
        c0 = clear_cnt; d0 = done_cnt; r0 = rd_cnt;
        issue(7, 9, 0);
        chk("zero_done_pulse", seq_done, 1);
        chk("zero_cmd_ready_low", bus.cmd_ready, 0);
        @(posedge clk); #1;
        chk("zero_done_drop", seq_done, 0);
        chk("zero_cmd_ready_back", bus.cmd_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("zero_done_cnt", done_cnt - d0, 1);
        chk("zero_clear", clear_cnt - c0, 0);
        chk("zero_rd", rd_cnt - r0, 0);

        // reset asserted during feed beat 2
        issue(40, 60, 1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            ok = rd_en;
        end
        chk("rst_reach_feed", ok, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pre_rd_en", rd_en, 1);
        rst = 1'b1;
        #1;
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_rd_addr", {rd_a_addr, rd_b_addr}, 0);
        chk("arst_feed_valid", arr_feed_valid, 0);
        chk("arst_res_valid", bus.res_valid, 0);
        exp_ra.delete(); exp_rb.delete(); exp_rd.delete(); exp_rr.delete(); exp_rl.delete();
        exp_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        r0 = row_cnt; d0 = done_cnt;
        issue(40, 60, 1);
        wait_done(d0);
        chk("post_rst_rows", row_cnt - r0, 4);

        // spurious done in idle sets the sticky error
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        exp_err = 1'b1;
        chk("err_set", seq_err, 1);
        r0 = row_cnt; d0 = done_cnt;
        issue(0, 100, 1);
        wait_done(d0);
        chk("err_sticky", seq_err, 1);
        chk("err_rows", row_cnt - r0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
